// File: rtl/hrm_outbox_uart_pkg.sv
// ============================================================================
//  Module  : hrm_outbox_uart_pkg
//  Purpose : Shared types and constants for the OUTBOX UART slice:
//            TX state encoding and 8N1 frame constants.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package hrm_outbox_uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'b00,
    TX_START = 2'b01,
    TX_DATA  = 2'b10,
    TX_STOP  = 2'b11
  } tx_state_t;

  localparam int c_data_bits  = 8;
  localparam int c_frame_bits = 10;

endpackage

`default_nettype wire

// File: rtl/hrm_sync_fifo.sv
// ============================================================================
//  Module  : hrm_sync_fifo
//  Purpose : Single-clock byte FIFO with combinational head read.
//            Shared between the outbox and the inbox.
//  Ports   : clk, i_rst      - clock, synchronous active-high reset
//            i_push, i_din   - enqueue strobe and data (ignored when full)
//            i_pop           - dequeue strobe (ignored when empty)
//            o_dout          - current head entry
//            o_count         - occupancy 0..2**DEPTH_LOG2
//            o_full, o_empty - decoded from the registered count
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module hrm_sync_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [7:0]            i_din,
  output logic [7:0]            o_dout,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int                c_depth     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_depth_cnt = (DEPTH_LOG2+1)'(c_depth);
  localparam logic [DEPTH_LOG2:0] c_cnt_one   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);

  logic [7:0]            r_mem [0:c_depth-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == c_depth_cnt);
  assign w_empty = (r_count == '0);
  // A push against a full FIFO is dropped even if a pop happens on the same
  // edge; the writer sees o_full and is expected to retry.
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop  && !w_empty;

  // Storage carries no reset: contents are only meaningful below r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/hrm_outbox_uart.sv
// ============================================================================
//  Module  : hrm_outbox_uart
//  Purpose : OUTBOX responder. Buffers bytes strobed by the control unit and
//            serialises them as UART 8N1, LSB first, back-to-back frames.
//  Ports   : clk, i_rst  - clock, synchronous active-high reset
//            i_data      - byte from register R
//            i_wO        - write strobe from the control unit
//            o_full      - FIFO full (to CU outFull, stalls OUTBOX)
//            o_empty     - FIFO empty
//            o_count     - FIFO occupancy
//            o_tx        - registered UART line, idles high
//            o_busy      - frame in progress
//            o_ovf       - sticky: a write was dropped while full
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module hrm_outbox_uart
  import hrm_outbox_uart_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic [7:0]          i_data,
  input  logic                i_wO,
  output logic                o_full,
  output logic                o_empty,
  output logic [DEPTH_LOG2:0] o_count,
  output logic                o_tx,
  output logic                o_busy,
  output logic                o_ovf
);

  localparam int              c_tw       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_tw-1:0] c_tmax     = c_tw'(CLKS_PER_BIT - 1);
  localparam logic [c_tw-1:0] c_tone     = c_tw'(1);
  localparam logic [2:0]      c_last_bit = 3'(c_data_bits - 1);

  // FIFO interface
  logic       w_pop;
  logic [7:0] w_head;
  logic       w_full;
  logic       w_empty;

  // TX registers and their next-state values
  tx_state_t       r_state,   w_state;
  logic [c_tw-1:0] r_timer,   w_timer;
  logic [2:0]      r_bit_idx, w_bit_idx;
  logic [7:0]      r_shift,   w_shift;
  logic            r_tx,      w_tx;
  logic            r_busy,    w_busy;
  logic            r_ovf;
  logic            w_tick;

  hrm_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_push  (i_wO),
    .i_pop   (w_pop),
    .i_din   (i_data),
    .o_dout  (w_head),
    .o_count (o_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_tick = (r_timer == c_tmax);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state   <= TX_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_timer   <= w_timer;
      r_bit_idx <= w_bit_idx;
      r_shift   <= w_shift;
      r_tx      <= w_tx;
      r_busy    <= w_busy;
    end
  end

  // Sticky overflow: set by any write attempted while the FIFO is full.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else if (i_wO && w_full) begin
      r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_timer   = r_timer + c_tone;
    w_bit_idx = r_bit_idx;
    w_shift   = r_shift;
    w_tx      = r_tx;
    w_busy    = r_busy;
    w_pop     = 1'b0;

    case (r_state)
      TX_IDLE: begin
        w_timer = '0;
        w_tx    = 1'b1;
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_shift = w_head;
          w_state = TX_START;
          w_tx    = 1'b0;
          w_busy  = 1'b1;
        end
      end

      TX_START: begin
        if (w_tick) begin
          w_timer   = '0;
          w_state   = TX_DATA;
          w_tx      = r_shift[0];
          w_bit_idx = '0;
        end
      end

      TX_DATA: begin
        if (w_tick) begin
          w_timer = '0;
          if (r_bit_idx == c_last_bit) begin
            w_state = TX_STOP;
            w_tx    = 1'b1;
          end else begin
            // r_shift[0] is on the line; expose the next bit.
            w_shift   = {1'b0, r_shift[7:1]};
            w_tx      = r_shift[1];
            w_bit_idx = r_bit_idx + 3'd1;
          end
        end
      end

      TX_STOP: begin
        if (w_tick) begin
          w_timer = '0;
          if (!w_empty) begin
            // Chain straight into the next start bit, no idle gap.
            w_pop   = 1'b1;
            w_shift = w_head;
            w_state = TX_START;
            w_tx    = 1'b0;
          end else begin
            w_state = TX_IDLE;
            w_busy  = 1'b0;
          end
        end
      end

      default: begin
        w_state = TX_IDLE;
        w_timer = '0;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_tx    = r_tx;
  assign o_busy  = r_busy;
  assign o_ovf   = r_ovf;

endmodule

`default_nettype wire
